// File: rtl/if_prefetch_stage_pkg.sv
// Shared defaults and redirect-source decoding for the prefetching fetch stage.
package if_prefetch_stage_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam int          DEPTH_DEF    = 4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_BJ   = 2'd1,
        RD_MRET = 2'd2,
        RD_EXP  = 2'd3
    } redirect_src_e;

    // Trap beats mret beats branch/jump when several arrive together.
    function automatic redirect_src_e redirect_src(input logic exp_i, input logic mret_i,
                                                   input logic bj_i);
        redirect_src_e src;
        if (exp_i) begin
            src = RD_EXP;
        end else if (mret_i) begin
            src = RD_MRET;
        end else if (bj_i) begin
            src = RD_BJ;
        end else begin
            src = RD_NONE;
        end
        return src;
    endfunction

endpackage

// File: rtl/if_prefetch_stage_if.sv
// Instruction-bus read channel: request (valid/ready/addr) and in-order response (valid/data).
interface if_prefetch_stage_if
    import if_prefetch_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
);
    logic            ibus_req_valid;
    logic [XLEN-1:0] ibus_req_addr;
    logic            ibus_req_ready;
    logic            ibus_rsp_valid;
    logic [XLEN-1:0] ibus_rsp_data;

    modport master (
        output ibus_req_valid, ibus_req_addr,
        input  ibus_req_ready, ibus_rsp_valid, ibus_rsp_data
    );

    modport slave (
        input  ibus_req_valid, ibus_req_addr,
        output ibus_req_ready, ibus_rsp_valid, ibus_rsp_data
    );
endinterface

// File: rtl/if_prefetch_stage_chk.sv
// Bus protocol checker for the prefetch stage's response channel.
module if_prefetch_stage_chk #(
    parameter int PTR_W = 3
) (
    input logic             clk,
    input logic             rst,
    input logic             rsp_valid_i,
    input logic [PTR_W-1:0] outstanding_i
);
    rsp_has_owner_a: assert property (@(posedge clk) disable iff (rst)
        rsp_valid_i |-> (outstanding_i != '0))
        else $error("ibus response arrived with no read outstanding");
endmodule

// File: rtl/if_prefetch_stage_fetch_queue.sv
// In-order circular buffer of fetched words: entries are allocated at issue, filled by
// responses in order, and popped toward ID once filled.
module if_prefetch_stage_fetch_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   alloc_i,
    input  logic [XLEN-1:0]        alloc_pc_i,
    input  logic                   alloc_misal_i,
    input  logic                   fill_i,
    input  logic [XLEN-1:0]        fill_data_i,
    input  logic                   pop_i,
    output logic                   head_valid_o,
    output logic [XLEN-1:0]        head_pc_o,
    output logic [XLEN-1:0]        head_inst_o,
    output logic                   head_misal_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] occupancy_o
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [XLEN-1:0]  pc_q   [DEPTH];
    logic [XLEN-1:0]  inst_q [DEPTH];
    logic [DEPTH-1:0] filled_q;
    logic [DEPTH-1:0] misal_q;
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d, fp_q, fp_d;
    logic [IDX_W-1:0] wr_idx_s, rd_idx_s, fp_idx_s;
    logic             empty_s, do_alloc_s, do_fill_s, do_pop_s;

    // Head view, handshake qualification and pointer next-state (fp = oldest unfilled entry).
    always_comb begin
        wr_idx_s     = wr_q[IDX_W-1:0];
        rd_idx_s     = rd_q[IDX_W-1:0];
        fp_idx_s     = fp_q[IDX_W-1:0];
        occupancy_o  = wr_q - rd_q;
        empty_s      = (wr_q == rd_q);
        full_o       = (occupancy_o == PTR_W'(DEPTH));
        head_valid_o = !empty_s && filled_q[rd_idx_s];
        head_pc_o    = pc_q[rd_idx_s];
        head_inst_o  = inst_q[rd_idx_s];
        head_misal_o = misal_q[rd_idx_s];
        do_alloc_s   = alloc_i && !full_o && !flush_i;
        do_fill_s    = fill_i && !flush_i;
        do_pop_s     = pop_i && head_valid_o && !flush_i;
        wr_d = flush_i ? '0 : (wr_q + PTR_W'(do_alloc_s));
        rd_d = flush_i ? '0 : (rd_q + PTR_W'(do_pop_s));
        fp_d = flush_i ? '0 : (fp_q + PTR_W'(do_fill_s));
    end

    // Entry storage and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
            end
            filled_q <= '0;
            misal_q  <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            fp_q     <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            fp_q <= fp_d;
            if (do_alloc_s) begin
                pc_q[wr_idx_s]     <= alloc_pc_i;
                inst_q[wr_idx_s]   <= '0;
                filled_q[wr_idx_s] <= alloc_misal_i;
                misal_q[wr_idx_s]  <= alloc_misal_i;
            end
            if (do_fill_s) begin
                inst_q[fp_idx_s]   <= fill_data_i;
                filled_q[fp_idx_s] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/if_prefetch_stage.sv
// Prefetching fetch stage: issues word reads, tracks in-flight/stale reads, redirects with
// trap > mret > branch priority, and hands {pc, inst, exception} to ID from an in-order queue.
module if_prefetch_stage
    import if_prefetch_stage_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              DEPTH    = DEPTH_DEF,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       bj_flag,
    input  logic [XLEN-1:0]            bj_addr,
    input  logic                       jump2exp,
    input  logic [XLEN-1:0]            meh_addr,
    input  logic                       ex_is_mret_inst,
    input  logic [XLEN-1:0]            mret_addr,
    input  logic                       pipe_stall,
    input  logic                       id_allowin,
    if_prefetch_stage_if.master        ibus,
    output logic                       if_id_valid,
    output logic [XLEN-1:0]            if_pc,
    output logic [XLEN-1:0]            if_inst,
    output logic                       if_exp_flag,
    output logic                       if_inst_addr_misal
);
    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d, target_s;
    logic [PTR_W-1:0] inflight_q, inflight_d, drop_cnt_q, drop_cnt_d;
    logic [PTR_W-1:0] occupancy_s, outstanding_s;
    logic             halted_q, halted_d;
    redirect_src_e    src_s;
    logic             redirect_s, aligned_s, space_s, req_valid_s, issue_s, misal_alloc_s;
    logic             rsp_drop_s, rsp_fill_s, pop_s, full_s, head_valid_s, head_misal_s;

    // Redirect selection and issue/response/pop qualification.
    always_comb begin
        src_s      = redirect_src(jump2exp, ex_is_mret_inst, bj_flag);
        redirect_s = (src_s != RD_NONE);
        case (src_s)
            RD_EXP:  target_s = meh_addr;
            RD_MRET: target_s = mret_addr;
            RD_BJ:   target_s = bj_addr;
            default: target_s = fetch_pc_q;
        endcase
        aligned_s     = (fetch_pc_q[1:0] == 2'b00);
        outstanding_s = inflight_q + drop_cnt_q;
        // Stale reads still occupy the bus window, so they count against DEPTH too.
        space_s       = (CNT_W'(occupancy_s) + CNT_W'(drop_cnt_q)) < CNT_W'(DEPTH);
        req_valid_s   = !rst && !redirect_s && !halted_q && aligned_s && space_s;
        issue_s       = req_valid_s && ibus.ibus_req_ready;
        misal_alloc_s = !rst && !redirect_s && !halted_q && !aligned_s && !full_s;
        rsp_drop_s    = ibus.ibus_rsp_valid && (drop_cnt_q != '0);
        rsp_fill_s    = ibus.ibus_rsp_valid && (drop_cnt_q == '0) && !redirect_s;
        pop_s         = head_valid_s && id_allowin && !pipe_stall;
    end

    // Fetch PC, halt flag and read-accounting next state.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        halted_d   = halted_q;
        inflight_d = inflight_q;
        drop_cnt_d = drop_cnt_q;
        if (redirect_s) begin
            fetch_pc_d = target_s;
            halted_d   = 1'b0;
            inflight_d = '0;
            drop_cnt_d = outstanding_s - PTR_W'(ibus.ibus_rsp_valid);
        end else begin
            fetch_pc_d = issue_s ? (fetch_pc_q + XLEN'(4)) : fetch_pc_q;
            halted_d   = halted_q || misal_alloc_s;
            inflight_d = inflight_q + PTR_W'(issue_s) - PTR_W'(rsp_fill_s);
            drop_cnt_d = drop_cnt_q - PTR_W'(rsp_drop_s);
        end
    end

    // Fetch-control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            halted_q   <= 1'b0;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            halted_q   <= halted_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign ibus.ibus_req_valid = req_valid_s;
    assign ibus.ibus_req_addr  = {fetch_pc_q[XLEN-1:2], 2'b00};

    if_prefetch_stage_fetch_queue #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (redirect_s),
        .alloc_i       (issue_s || misal_alloc_s),
        .alloc_pc_i    (fetch_pc_q),
        .alloc_misal_i (misal_alloc_s),
        .fill_i        (rsp_fill_s),
        .fill_data_i   (ibus.ibus_rsp_data),
        .pop_i         (pop_s),
        .head_valid_o  (head_valid_s),
        .head_pc_o     (if_pc),
        .head_inst_o   (if_inst),
        .head_misal_o  (head_misal_s),
        .full_o        (full_s),
        .occupancy_o   (occupancy_s)
    );

    assign if_id_valid        = head_valid_s;
    assign if_exp_flag        = head_misal_s;
    assign if_inst_addr_misal = head_misal_s;

    if_prefetch_stage_chk #(
        .PTR_W (PTR_W)
    ) u_chk (
        .clk           (clk),
        .rst           (rst),
        .rsp_valid_i   (ibus.ibus_rsp_valid),
        .outstanding_i (outstanding_s)
    );

endmodule
